// File: rtl/boot_pkg.sv
// Shared types and constants for the boot loader: FSM states, error codes and image limits.
package boot_pkg;

    typedef enum logic [3:0] {
        IDLE,
        HDR_REQ,
        HDR_CAP,
        REQ,
        CAP,
        WR,
        CS_REQ,
        CS_CAP,
        DONE,
        ERR
    } boot_state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_MAGIC = 2'b01;
    localparam logic [1:0] ERR_LEN   = 2'b10;
    localparam logic [1:0] ERR_CSUM  = 2'b11;

    localparam logic [15:0] MAGIC_DEFAULT = 16'hB007;
    localparam int          MAX_LEN       = 126;

    // Payload length must leave room for the checksum word inside the 128-word ROM.
    function automatic logic len_ok(input logic [6:0] n);
        return (n != 7'd0) && (int'(n) <= MAX_LEN);
    endfunction

endpackage

// File: rtl/boot_loader_csum.sv
// 32-bit wrapping payload accumulator; sum_zero reports whether sum plus the checksum word is zero.
module boot_loader_csum #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              add_en,
    input  logic [DATA_W-1:0] add_data,
    input  logic [DATA_W-1:0] chk_data,
    output logic              sum_zero
);

    logic [DATA_W-1:0] sum_reg;
    logic [DATA_W-1:0] total;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sum_reg <= '0;
        end else if (clear) begin
            sum_reg <= '0;
        end else if (add_en) begin
            sum_reg <= sum_reg + add_data;
        end
    end

    assign total    = sum_reg + chk_data;
    assign sum_zero = (total == '0);

endmodule

// File: rtl/boot_loader.sv
// Boot sequencer: validates the ROM image header and checksum, copies the payload to
// instruction memory, and releases the processor reset only after a clean copy.
module boot_loader
    import boot_pkg::*;
#(
    parameter int          ADDR_W     = 7,
    parameter int          DATA_W     = 32,
    parameter int          DST_AW     = 12,
    parameter logic [15:0] MAGIC      = MAGIC_DEFAULT,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              dst_valid,
    input  logic              dst_ready,
    output logic [DST_AW-1:0] dst_addr,
    output logic [DATA_W-1:0] dst_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              cpu_reset_n
);

    boot_state_t       state_reg, state_next;
    logic [6:0]        len_reg, len_next;
    logic [6:0]        count_reg, count_next;
    logic [1:0]        err_code_reg, err_code_next;
    logic [DST_AW-1:0] dst_addr_reg;
    logic [DATA_W-1:0] dst_wdata_reg;
    logic              start_load;
    logic              acc_add;
    logic              sum_zero;

    boot_loader_csum #(.DATA_W(DATA_W)) u_csum (
        .clk      (clk),
        .reset    (reset),
        .clear    (start_load),
        .add_en   (acc_add),
        .add_data (rom_data),
        .chk_data (rom_data),
        .sum_zero (sum_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            len_reg       <= '0;
            count_reg     <= '0;
            err_code_reg  <= ERR_NONE;
            dst_addr_reg  <= '0;
            dst_wdata_reg <= '0;
        end else begin
            state_reg    <= state_next;
            len_reg      <= len_next;
            count_reg    <= count_next;
            err_code_reg <= err_code_next;
            if (state_reg == CAP) begin
                dst_addr_reg  <= DST_AW'(count_reg);
                dst_wdata_reg <= rom_data;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        len_next      = len_reg;
        count_next    = count_reg;
        err_code_next = err_code_reg;
        start_load    = 1'b0;
        acc_add       = 1'b0;
        rom_en        = 1'b0;
        rom_addr      = '0;
        dst_valid     = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        err           = 1'b0;
        cpu_reset_n   = 1'b0;

        case (state_reg)
            IDLE: begin
                busy       = 1'b0;
                start_load = start | AUTO_START;
            end
            HDR_REQ: begin
                rom_en     = 1'b1;
                state_next = HDR_CAP;
            end
            HDR_CAP: begin
                if (rom_data[31:16] != MAGIC || rom_data[15:7] != 9'd0) begin
                    state_next    = ERR;
                    err_code_next = ERR_MAGIC;
                end else if (!len_ok(rom_data[6:0])) begin
                    state_next    = ERR;
                    err_code_next = ERR_LEN;
                end else begin
                    len_next   = rom_data[6:0];
                    state_next = REQ;
                end
            end
            REQ: begin
                rom_en     = 1'b1;
                rom_addr   = ADDR_W'(count_reg + 7'd1);
                state_next = CAP;
            end
            CAP: begin
                acc_add    = 1'b1;
                state_next = WR;
            end
            WR: begin
                dst_valid = 1'b1;
                if (dst_ready) begin
                    count_next = count_reg + 7'd1;
                    state_next = (count_reg + 7'd1 == len_reg) ? CS_REQ : REQ;
                end
            end
            CS_REQ: begin
                rom_en     = 1'b1;
                rom_addr   = ADDR_W'(len_reg + 7'd1);
                state_next = CS_CAP;
            end
            CS_CAP: begin
                if (sum_zero) begin
                    state_next = DONE;
                end else begin
                    state_next    = ERR;
                    err_code_next = ERR_CSUM;
                end
            end
            DONE: begin
                busy        = 1'b0;
                done        = 1'b1;
                cpu_reset_n = 1'b1;
                start_load  = start;
            end
            ERR: begin
                busy       = 1'b0;
                err        = 1'b1;
                start_load = start;
            end
            default: state_next = IDLE;
        endcase

        // A new load always restarts from a clean slate, whatever state it came from.
        if (start_load) begin
            state_next    = HDR_REQ;
            count_next    = '0;
            err_code_next = ERR_NONE;
        end
    end

    assign dst_addr  = dst_addr_reg;
    assign dst_wdata = dst_wdata_reg;
    assign err_code  = err_code_reg;

endmodule

// File: tb/tb_boot_loader.sv
// Randomized bench for boot_loader: a ROM model feeds images, and an image-level reference
// model predicts the outcome code and the exact list of destination writes.
module tb_boot_loader;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;
    localparam int DST_AW = 12;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              dst_valid;
    logic              dst_ready = 1'b1;
    logic [DST_AW-1:0] dst_addr;
    logic [DATA_W-1:0] dst_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        err_code;
    logic              cpu_reset_n;

    int checks = 0;
    int errors = 0;

    logic [31:0] rom [128];
    int          bp_mode = 0;
    int          bp_cnt  = 0;

    logic [DST_AW-1:0] wr_addr_q [$];
    logic [31:0]       wr_data_q [$];
    logic [31:0]       exp_data_q[$];
    int                exp_code;

    int                stab_err = 0;
    logic              pend = 1'b0;
    logic [DST_AW-1:0] pend_addr;
    logic [31:0]       pend_data;

    logic first_busy;
    logic first_crn;

    boot_loader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DST_AW(DST_AW),
        .MAGIC(16'hB007), .AUTO_START(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .dst_valid(dst_valid), .dst_ready(dst_ready),
        .dst_addr(dst_addr), .dst_wdata(dst_wdata),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .cpu_reset_n(cpu_reset_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_en) rom_data <= rom[rom_addr];
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode == 0) begin
                dst_ready = 1'b1;
            end else if (bp_mode == 1) begin
                dst_ready = ($urandom % 3) != 0;
            end else begin
                if (!dst_valid) begin
                    bp_cnt = 0;
                    dst_ready = 1'b0;
                end else if (bp_cnt < 5) begin
                    bp_cnt = bp_cnt + 1;
                    dst_ready = 1'b0;
                end else begin
                    dst_ready = 1'b1;
                end
            end
        end
    end

    // Handshake log and hold-stability watch, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset && pend && dst_valid && (dst_addr !== pend_addr || dst_wdata !== pend_data))
            stab_err <= stab_err + 1;
        if (reset && pend && !dst_valid)
            stab_err <= stab_err + 1;
        if (reset && dst_valid && dst_ready) begin
            wr_addr_q.push_back(dst_addr);
            wr_data_q.push_back(dst_wdata);
        end
        pend      <= reset && dst_valid && !dst_ready;
        pend_addr <= dst_addr;
        pend_data <= dst_wdata;
    end

    // Reference outcome straight from the image rules.
    task automatic model();
        int          n;
        logic [31:0] s;
        logic [31:0] t;
        exp_data_q.delete();
        n = int'(rom[0][6:0]);
        if (rom[0][31:16] != 16'hB007 || rom[0][15:7] != 9'd0) begin
            exp_code = 1;
            return;
        end
        if (n < 1 || n > 126) begin
            exp_code = 2;
            return;
        end
        s = 32'd0;
        for (int i = 1; i <= n; i++) begin
            s = s + rom[i];
            exp_data_q.push_back(rom[i]);
        end
        t = s + rom[n + 1];
        exp_code = (t == 32'd0) ? 0 : 3;
    endtask

    function automatic int log_diffs();
        int d = 0;
        for (int i = 0; i < wr_data_q.size() && i < exp_data_q.size(); i++) begin
            if (wr_addr_q[i] !== DST_AW'(i) || wr_data_q[i] !== exp_data_q[i]) d++;
        end
        return d;
    endfunction

    task automatic random_image(input int n, input bit good);
        logic [31:0] s = 32'd0;
        for (int i = 0; i < 128; i++) rom[i] = $urandom;
        rom[0] = {16'hB007, 9'd0, 7'(n)};
        for (int i = 1; i <= n; i++) s = s + rom[i];
        rom[n + 1] = good ? (32'd0 - s) : (32'd0 - s + 32'd1 + ($urandom % 1000));
    endtask

    task automatic spec_image();
        for (int i = 0; i < 128; i++) rom[i] = $urandom;
        rom[0] = 32'hB007_0004;
        for (int i = 1; i <= 4; i++) rom[i] = 32'(i);
        rom[5] = 32'hFFFF_FFF6;
    endtask

    // Caller is at posedge+1; edges counts from the edge that samples start (or reset release).
    task automatic run_load(input bit use_start, input bit noisy, output int edges);
        int e = 0;
        bit fin = 1'b0;
        wr_addr_q.delete();
        wr_data_q.delete();
        if (use_start) start = 1'b1;
        while (!fin && e < 3000) begin
            @(posedge clk);
            e++;
            #1;
            if (e == 1) begin
                start = 1'b0;
                first_busy = busy;
                first_crn  = cpu_reset_n;
            end else if (noisy) begin
                start = busy && (($urandom % 3) == 0);
            end
            if (done || err) fin = 1'b1;
        end
        start = 1'b0;
        edges = fin ? e : -1;
        if (!fin) $display("FAIL load_timeout: got no done/err after %0d edges, expected completion", e);
    endtask

    task automatic test_reset();
        spec_image();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rom_en, rom_addr, dst_valid, busy, done, err, err_code, cpu_reset_n} !== 15'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got %0h expected 0", {rom_en, rom_addr, dst_valid, busy, done, err, err_code, cpu_reset_n});
        end
        checks++;
        if ({dst_addr, dst_wdata} !== 44'd0) begin
            errors++;
            $display("FAIL reset_data: got %0h expected 0", {dst_addr, dst_wdata});
        end
        $display("test_reset: outputs idle under reset");
    endtask

    task automatic test_good_image();
        int e;
        @(posedge clk);
        #1 reset = 1'b1;
        model();
        run_load(1'b0, 1'b0, e);
        checks++;
        if (e !== 17) begin errors++; $display("FAIL good_latency: got %0d expected 17", e); end
        checks++;
        if ({done, cpu_reset_n, err, busy, err_code} !== 6'b110000) begin
            errors++;
            $display("FAIL good_status: got %b expected 110000", {done, cpu_reset_n, err, busy, err_code});
        end
        checks++;
        if (wr_data_q.size() !== 4 || log_diffs() !== 0) begin
            errors++;
            $display("FAIL good_writes: got %0d writes/%0d diffs expected 4/0", wr_data_q.size(), log_diffs());
        end
        $display("test_good_image: N=4 done after %0d edges, %0d writes", e, wr_data_q.size());
    endtask

    task automatic test_backpressure();
        int e;
        int base = stab_err;
        spec_image();
        model();
        bp_mode = 2;
        run_load(1'b1, 1'b0, e);
        bp_mode = 0;
        checks++;
        if (stab_err - base !== 0) begin errors++; $display("FAIL bp_stable: got %0d violations expected 0", stab_err - base); end
        checks++;
        if (wr_data_q.size() !== 4 || log_diffs() !== 0) begin
            errors++;
            $display("FAIL bp_writes: got %0d writes/%0d diffs expected 4/0", wr_data_q.size(), log_diffs());
        end
        checks++;
        if (done !== 1'b1 || e !== 37) begin errors++; $display("FAIL bp_done: got done=%b edges=%0d expected 1/37", done, e); end
        $display("test_backpressure: done after %0d edges, %0d writes", e, wr_data_q.size());
    endtask

    task automatic test_bad_header();
        logic [31:0] hdrs [5];
        logic [15:0] m;
        int e;
        m = 16'($urandom);
        if (m == 16'hB007) m = m ^ 16'h0100;
        hdrs[0] = 32'hB006_0004;
        hdrs[1] = 32'hB007_0000;
        hdrs[2] = 32'hB007_007F;
        hdrs[3] = 32'hB007_8004;
        hdrs[4] = {m, 16'h0005};
        for (int k = 0; k < 5; k++) begin
            random_image(5, 1'b1);
            rom[0] = hdrs[k];
            model();
            run_load(1'b1, 1'b0, e);
            checks++;
            if (err !== 1'b1 || err_code !== 2'(exp_code)) begin
                errors++;
                $display("FAIL hdr_code[%0d]: got err=%b code=%0d expected 1/%0d", k, err, err_code, exp_code);
            end
            checks++;
            if (wr_data_q.size() !== 0 || cpu_reset_n !== 1'b0 || done !== 1'b0 || e !== 3) begin
                errors++;
                $display("FAIL hdr_quiet[%0d]: got writes=%0d crn=%b done=%b edges=%0d expected 0/0/0/3",
                         k, wr_data_q.size(), cpu_reset_n, done, e);
            end
            $display("test_bad_header: hdr=%h err_code=%0d", hdrs[k], err_code);
        end
    endtask

    task automatic test_csum_fail();
        int e;
        for (int i = 0; i < 128; i++) rom[i] = $urandom;
        rom[0] = 32'hB007_0002;
        rom[1] = 32'd5;
        rom[2] = 32'd6;
        rom[3] = 32'd0;
        model();
        run_load(1'b1, 1'b0, e);
        checks++;
        if (wr_data_q.size() !== 2 || log_diffs() !== 0) begin
            errors++;
            $display("FAIL cs_writes: got %0d writes/%0d diffs expected 2/0", wr_data_q.size(), log_diffs());
        end
        checks++;
        if ({err, err_code, cpu_reset_n, done} !== 5'b11100 || e !== 11) begin
            errors++;
            $display("FAIL cs_status: got %b edges=%0d expected 11100/11", {err, err_code, cpu_reset_n, done}, e);
        end
        $display("test_csum_fail: err_code=%0d after %0d edges", err_code, e);
    endtask

    task automatic test_random();
        int n;
        int e;
        int base;
        bit good;
        for (int k = 0; k < 6; k++) begin
            n = (k % 2 == 0) ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 126));
            good = ($urandom % 3) != 0;
            random_image(n, good);
            model();
            base = stab_err;
            bp_mode = 1;
            run_load(1'b1, 1'b1, e);
            bp_mode = 0;
            checks++;
            if (err_code !== 2'(exp_code) || done !== (exp_code == 0) || err !== (exp_code != 0)) begin
                errors++;
                $display("FAIL rnd_status[%0d]: got code=%0d done=%b err=%b expected code=%0d", k, err_code, done, err, exp_code);
            end
            checks++;
            if (wr_data_q.size() !== exp_data_q.size() || log_diffs() !== 0 || stab_err - base !== 0) begin
                errors++;
                $display("FAIL rnd_writes[%0d]: got %0d writes/%0d diffs/%0d unstable expected %0d/0/0",
                         k, wr_data_q.size(), log_diffs(), stab_err - base, exp_data_q.size());
            end
            $display("test_random: N=%0d good=%0d code=%0d writes=%0d", n, good, err_code, wr_data_q.size());
        end
    endtask

    task automatic test_reset_midload();
        int wr_cycles = 0;
        int guard = 0;
        int e;
        random_image(126, 1'b1);
        model();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (wr_cycles < 10 && guard < 500) begin
            @(negedge clk);
            guard++;
            if (dst_valid) wr_cycles++;
        end
        checks++;
        if (wr_cycles !== 10) begin errors++; $display("FAIL mid_reach: got %0d WR cycles expected 10", wr_cycles); end
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({dst_valid, busy, cpu_reset_n, done, err, err_code} !== 7'd0) begin
            errors++;
            $display("FAIL mid_reset: got %b expected 0000000", {dst_valid, busy, cpu_reset_n, done, err, err_code});
        end
        reset = 1'b1;
        run_load(1'b0, 1'b0, e);
        checks++;
        if (done !== 1'b1 || e !== 383 || wr_data_q.size() !== 126 || log_diffs() !== 0) begin
            errors++;
            $display("FAIL mid_reload: got done=%b edges=%0d writes=%0d diffs=%0d expected 1/383/126/0",
                     done, e, wr_data_q.size(), log_diffs());
        end
        $display("test_reset_midload: reload done after %0d edges", e);
    endtask

    task automatic test_back_to_back();
        int n;
        int e;
        for (int k = 0; k < 2; k++) begin
            n = int'($urandom_range(1, 20));
            random_image(n, 1'b1);
            model();
            run_load(1'b1, 1'b1, e);
            checks++;
            if (first_crn !== 1'b0 || first_busy !== 1'b1) begin
                errors++;
                $display("FAIL restart_edge1: got crn=%b busy=%b expected 0/1", first_crn, first_busy);
            end
            checks++;
            if (done !== 1'b1 || cpu_reset_n !== 1'b1 || e !== 3 * n + 5) begin
                errors++;
                $display("FAIL restart_done: got done=%b crn=%b edges=%0d expected 1/1/%0d", done, cpu_reset_n, e, 3 * n + 5);
            end
            checks++;
            if (wr_data_q.size() !== n || log_diffs() !== 0) begin
                errors++;
                $display("FAIL restart_writes: got %0d writes/%0d diffs expected %0d/0", wr_data_q.size(), log_diffs(), n);
            end
            $display("test_back_to_back: N=%0d done after %0d edges", n, e);
        end
    endtask

    initial begin
        test_reset();
        test_good_image();
        test_backpressure();
        test_bad_header();
        test_csum_fail();
        test_random();
        test_reset_midload();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
